// File: rtl/seq_event_pkg.sv
// Shared types and default widths for the seq_event stimulus generator.
package seq_event_pkg;

    localparam int unsigned DEF_GAP_W = 4;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        GOOD   = 2'd0,
        DROP_B = 2'd1,
        DROP_C = 2'd2,
        LATE_C = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PA   = 3'd1,
        S_PB   = 3'd2,
        S_PC   = 3'd3,
        S_PC2  = 3'd4,
        S_GAP  = 3'd5,
        S_FIN  = 3'd6
    } state_e;

endpackage

// File: rtl/seq_event_stim.sv
// Burst generator of a ##1 b ##1 c sequences with optional fault injection,
// plus a free-running divide-by-2 clk2 for the downstream seq_event block.
module seq_event_stim
    import seq_event_pkg::*;
#(
    parameter int unsigned GAP_W = DEF_GAP_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [GAP_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             clk2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued
);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic             seq_end;
    logic [CNT_W-1:0] issued_inc;
    logic             a_d, b_d, c_d;

    // Next state and next stimulus; outputs are registered from the next state
    // so stimulus appears in the same cycle the state is entered.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        seq_end    = 1'b0;
        issued_inc = (issued == '1) ? issued : issued + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = (count == '0) ? S_FIN : S_PA;
                end
            end
            S_PA:  state_d = S_PB;
            S_PB:  state_d = S_PC;
            S_PC: begin
                if (mode_q == LATE_C) begin
                    state_d = S_PC2;
                end else begin
                    seq_end = 1'b1;
                end
            end
            S_PC2: seq_end = 1'b1;
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = S_PA;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (seq_end) begin
            if (issued_inc == count_q) begin
                state_d = S_FIN;
            end else if (gap_q == '0) begin
                state_d = S_PA;
            end else begin
                state_d = S_GAP;
            end
        end

        // Abort wins over everything, including a sequence completing this cycle.
        if (abort) begin
            state_d = S_IDLE;
            seq_end = 1'b0;
        end

        a_d = (state_d == S_PA);
        b_d = (state_d == S_PB) && (mode_q != DROP_B);
        c_d = ((state_d == S_PC) && ((mode_q == GOOD) || (mode_q == DROP_B)))
            || (state_d == S_PC2);
    end

    // State, latched burst parameters, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= GOOD;
            gap_q   <= '0;
            count_q <= '0;
            gap_cnt <= '0;
            issued  <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            c       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            clk2    <= 1'b0;
        end else begin
            state_q <= state_d;
            a       <= a_d;
            b       <= b_d;
            c       <= c_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_FIN);
            clk2    <= ~clk2;

            if (accept) begin
                mode_q  <= mode_e'(mode);
                gap_q   <= gap;
                count_q <= count;
                issued  <= '0;
            end else if (seq_end) begin
                issued  <= issued_inc;
            end

            if (seq_end) begin
                gap_cnt <= gap_q - GAP_W'(1);
            end else if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_event_stim.sv
// Directed bench for seq_event_stim: per-cycle expected {a,b,c,busy,done} vectors.
module tb_seq_event_stim;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [3:0] gap;
    logic [7:0] count;
    logic       a, b, c, clk2, busy, done;
    logic [7:0] issued;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        exp_clk2 = 1'b0;

    seq_event_stim #(.GAP_W(4), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .mode   (mode),
        .gap    (gap),
        .count  (count),
        .a      (a),
        .b      (b),
        .c      (c),
        .clk2   (clk2),
        .busy   (busy),
        .done   (done),
        .issued (issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        exp_clk2 = rst ? 1'b0 : ~exp_clk2;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; start/abort are single-cycle requests. exp = {a,b,c,busy,done}.
    task automatic cyc(input string tag, input logic [4:0] exp);
        step();
        start = 1'b0;
        abort = 1'b0;
        chk(tag, {27'd0, a, b, c, busy, done}, {27'd0, exp});
        chk({tag, "_clk2"}, {31'd0, clk2}, {31'd0, exp_clk2});
    endtask

    task automatic start_burst(input logic [1:0] m, input logic [3:0] g, input logic [7:0] n);
        mode  = m;
        gap   = g;
        count = n;
        start = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'd0; gap = 4'd0; count = 8'd0;
        step();
        step();
        chk("rst_out", {27'd0, a, b, c, busy, done}, 32'd0);
        chk("rst_issued", {24'd0, issued}, 32'd0);
        chk("rst_clk2", {31'd0, clk2}, 32'd0);
        rst = 1'b0;
        cyc("idle0", 5'b00000);

        // GOOD, count=2, gap=0
        start_burst(2'd0, 4'd0, 8'd2);
        cyc("g_a1", 5'b10010);
        cyc("g_b1", 5'b01010);
        cyc("g_c1", 5'b00110);
        cyc("g_a2", 5'b10010);
        chk("g_iss1", {24'd0, issued}, 32'd1);
        cyc("g_b2", 5'b01010);
        cyc("g_c2", 5'b00110);
        cyc("g_done", 5'b00011);
        chk("g_iss2", {24'd0, issued}, 32'd2);
        cyc("g_idle", 5'b00000);

        // DROP_B, count=1, gap=2
        start_burst(2'd1, 4'd2, 8'd1);
        cyc("db_a", 5'b10010);
        cyc("db_nob", 5'b00010);
        cyc("db_c", 5'b00110);
        cyc("db_done", 5'b00011);
        cyc("db_idle", 5'b00000);
        chk("db_iss", {24'd0, issued}, 32'd1);

        // LATE_C, count=2, gap=1
        start_burst(2'd3, 4'd1, 8'd2);
        cyc("lc_a1", 5'b10010);
        cyc("lc_b1", 5'b01010);
        cyc("lc_noc1", 5'b00010);
        cyc("lc_c1", 5'b00110);
        cyc("lc_gap", 5'b00010);
        cyc("lc_a2", 5'b10010);
        cyc("lc_b2", 5'b01010);
        cyc("lc_noc2", 5'b00010);
        cyc("lc_c2", 5'b00110);
        cyc("lc_done", 5'b00011);
        cyc("lc_idle", 5'b00000);
        chk("lc_iss", {24'd0, issued}, 32'd2);

        // count=0: immediate done, issued cleared
        start_burst(2'd0, 4'd0, 8'd0);
        cyc("z_done", 5'b00011);
        cyc("z_idle", 5'b00000);
        chk("z_iss", {24'd0, issued}, 32'd0);

        // start while busy is ignored; DROP_C stays latched
        start_burst(2'd2, 4'd0, 8'd1);
        cyc("dc_a", 5'b10010);
        mode = 2'd0; count = 8'd5; start = 1'b1;
        cyc("dc_b", 5'b01010);
        cyc("dc_noc", 5'b00010);
        cyc("dc_done", 5'b00011);
        cyc("dc_idle", 5'b00000);
        chk("dc_iss", {24'd0, issued}, 32'd1);

        // abort in PB of the second sequence
        start_burst(2'd0, 4'd0, 8'd4);
        cyc("ab_a1", 5'b10010);
        cyc("ab_b1", 5'b01010);
        cyc("ab_c1", 5'b00110);
        cyc("ab_a2", 5'b10010);
        cyc("ab_b2", 5'b01010);
        abort = 1'b1;
        cyc("ab_idle", 5'b00000);
        chk("ab_iss", {24'd0, issued}, 32'd1);
        cyc("ab_nodone", 5'b00000);

        // start and abort together in IDLE
        start_burst(2'd0, 4'd0, 8'd1);
        abort = 1'b1;
        cyc("sa_idle", 5'b00000);
        cyc("sa_idle2", 5'b00000);
        chk("sa_iss", {24'd0, issued}, 32'd1);

        // rst during GAP
        start_burst(2'd0, 4'd3, 8'd2);
        cyc("rg_a", 5'b10010);
        cyc("rg_b", 5'b01010);
        cyc("rg_c", 5'b00110);
        cyc("rg_gap", 5'b00010);
        chk("rg_iss_pre", {24'd0, issued}, 32'd1);
        rst = 1'b1;
        cyc("rg_rst", 5'b00000);
        chk("rg_iss", {24'd0, issued}, 32'd0);
        chk("rg_clk2", {31'd0, clk2}, 32'd0);
        rst = 1'b0;
        cyc("rg_t1", 5'b00000);
        chk("rg_clk2_hi", {31'd0, clk2}, 32'd1);
        cyc("rg_t2", 5'b00000);
        cyc("rg_t3", 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
